// File: rtl/sf_fifo_pkg.sv
// Shared defaults and helpers for the store-and-forward packet FIFO.
// Pointers carry one extra wrap bit above the address so full and empty can be told apart.
package sf_fifo_pkg;

  localparam int unsigned SfDepthLg2  = 4;
  localparam int unsigned SfDataWidth = 32;
  localparam int unsigned DropCntW    = 16;

  // Per-cycle classification of the write port.
  typedef enum logic [2:0] {
    WrNone,
    WrStore,
    WrPoison,
    WrCommit,
    WrDrop
  } wr_act_e;

  function automatic int unsigned sf_ptr_width(input int unsigned depth_lg2);
    return depth_lg2 + 1;
  endfunction

endpackage

// File: rtl/sf_packet_fifo.sv
// Store-and-forward packet FIFO: beats become readable only once their packet commits cleanly.
// Optional saturating drop counter on drop_cnt_o when SF_DROP_CNT_EN is defined.
module sf_packet_fifo
  import sf_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LG2  = SfDepthLg2,
  parameter int unsigned DATA_WIDTH = SfDataWidth
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wren_i,
  input  logic                  wlast_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  werror_i,
  output logic                  full_o,
  input  logic                  rden_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  empty_o,
  output logic                  drop_o
`ifdef SF_DROP_CNT_EN
  ,
  output logic [DropCntW-1:0]   drop_cnt_o
`endif
);

  localparam int unsigned PtrW      = sf_ptr_width(DEPTH_LG2);
  localparam int unsigned FifoDepth = 1 << DEPTH_LG2;

  typedef logic [PtrW-1:0] ptr_t;

  logic [DATA_WIDTH-1:0] mem_q [FifoDepth];

  ptr_t    rptr_q, rptr_d;
  ptr_t    wptr_q, wptr_d;
  ptr_t    cptr_q, cptr_d;
  logic    poison_q, poison_d;
  logic    drop_q, drop_d;
  ptr_t    occupancy;
  ptr_t    committed;
  logic    full;
  logic    empty;
  wr_act_e wr_act;

  assign occupancy = wptr_q - rptr_q;
  assign committed = cptr_q - rptr_q;
  assign full      = (occupancy == ptr_t'(FifoDepth));
  assign empty     = (rptr_q == cptr_q);

  // A last beat always resolves the packet; a full FIFO forces a drop regardless of werror_i.
  always_comb begin
    wr_act = WrNone;
    if (wren_i) begin
      if (wlast_i) begin
        wr_act = (werror_i || poison_q || full) ? WrDrop : WrCommit;
      end else if (full) begin
        wr_act = WrPoison;
      end else if (!poison_q) begin
        wr_act = WrStore;
      end
    end
  end

  always_comb begin
    rptr_d   = rptr_q;
    wptr_d   = wptr_q;
    cptr_d   = cptr_q;
    poison_d = poison_q;
    drop_d   = 1'b0;

    if (rden_i && !empty) begin
      rptr_d = rptr_q + ptr_t'(1);
    end

    unique case (wr_act)
      WrNone:   ;
      WrStore:  wptr_d = wptr_q + ptr_t'(1);
      WrPoison: poison_d = 1'b1;
      WrCommit: begin
        wptr_d = wptr_q + ptr_t'(1);
        cptr_d = wptr_q + ptr_t'(1);
      end
      // Rewinding to cptr can never cross rptr because rptr never passes cptr.
      WrDrop: begin
        wptr_d   = cptr_q;
        poison_d = 1'b0;
        drop_d   = 1'b1;
      end
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr_q   <= '0;
      wptr_q   <= '0;
      cptr_q   <= '0;
      poison_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
      cptr_q   <= cptr_d;
      poison_q <= poison_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_act == WrStore || wr_act == WrCommit) begin
      mem_q[wptr_q[DEPTH_LG2-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rptr_q[DEPTH_LG2-1:0]];
  assign full_o  = full;
  assign empty_o = empty;
  assign drop_o  = drop_q;

`ifdef SF_DROP_CNT_EN
  logic [DropCntW-1:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (drop_q && (drop_cnt_q != '1)) begin
      drop_cnt_q <= drop_cnt_q + DropCntW'(1);
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

  // Pointer ordering invariant: rptr <= cptr <= wptr <= rptr + depth.
  assert property (@(posedge clk) disable iff (!rst_n)
    (committed <= occupancy) && (occupancy <= ptr_t'(FifoDepth)));

endmodule

// File: doc/sf_packet_fifo.md
SF_PACKET_FIFO -- requirements
Module: sf_packet_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LG2, default 4, meaning log2 of entry count; FIFO_DEPTH = 1<<DEPTH_LG2.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning width of one beat.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port wren_i  input  1  write beat valid.
REQ-006 SHALL have port wlast_i  input  1  beat is last of packet.
REQ-007 SHALL have port wdata_i  input  DATA_WIDTH  write beat data.
REQ-008 SHALL have port werror_i  input  1  packet-error verdict from upstream checker; meaningful only with wren_i & wlast_i.
REQ-009 SHALL have port full_o  output  1  no free entry.
REQ-010 SHALL have port rden_i  input  1  pop request.
REQ-011 SHALL have port rdata_o  output  DATA_WIDTH  head-of-queue data, show-ahead.
REQ-012 SHALL have port empty_o  output  1  no committed beat readable.
REQ-013 SHALL have port drop_o  output  1  one-cycle pulse: packet discarded.

Function
REQ-014 SHALL keep rptr, wptr (speculative) and cptr (committed), each DEPTH_LG2+1 bits, wrapping modulo 2*FIFO_DEPTH.
REQ-015 SHALL store wdata_i at mem[wptr] and increment wptr when wren_i & !full_o & !poison.
REQ-016 SHALL assert full_o when (wptr - rptr) == FIFO_DEPTH.
REQ-017 SHALL assert empty_o when rptr == cptr; only committed beats are readable.
REQ-018 SHALL drive rdata_o = mem[rptr] combinationally; rden_i & !empty_o increments rptr; rden_i while empty is ignored.
REQ-019 SHALL, on wren_i & wlast_i with werror_i=0 and poison=0, set cptr to the post-write wptr (last beat included), visible as !empty_o next cycle.
REQ-020 SHALL, on wren_i & wlast_i with werror_i=1 or poison=1, set wptr <= cptr (rewind, last beat not stored), clear poison, pulse drop_o next cycle.
REQ-021 SHALL set poison when wren_i & full_o & !wlast_i; poisoned beats are not stored until the last beat resolves the packet.
REQ-022 SHALL treat wren_i & wlast_i & full_o as a drop (REQ-020) regardless of werror_i.
REQ-023 SHALL allow same-cycle read and write/commit/rewind; full_o/empty_o use registered pointers only.
REQ-024 SHALL never rewind wptr below rptr; cptr is always between rptr and wptr.

Reset
REQ-025 SHALL on !rst_n at clk edge clear rptr, wptr, cptr, poison, drop_o: empty_o=1, full_o=0, drop_o=0; memory not cleared.
REQ-026 SHALL discard any partially written packet when reset occurs mid-packet.

Configuration
REQ-027 SHALL, with SF_DROP_CNT_EN defined, add output drop_cnt_o (16 bits, reset 0, increments on each drop_o, saturates at 16'hFFFF).
REQ-028 SHALL, without SF_DROP_CNT_EN, have no drop_cnt_o port and no counter logic.

Structure
REQ-029 SHALL take DEPTH_LG2/DATA_WIDTH defaults and pointer width from shared package sf_fifo_pkg.
REQ-030 SHALL instantiate sub-module error_check on wdata_i to generate werror_i internally only in the top wrapper sf_fifo_top; sf_packet_fifo itself has no sub-module besides the inferred memory array.

Verification
REQ-031 SHALL cover: 3-beat packet, last werror_i=0 -> empty_o falls cycle after last, pops return beats in order.
REQ-032 SHALL cover: 3-beat packet, last werror_i=1 -> empty_o stays 1, drop_o pulses once, wptr==cptr.
REQ-033 SHALL cover: DEPTH_LG2=4, 17-beat packet no reads -> full_o at 16 beats, packet dropped, FIFO empty after.
REQ-034 SHALL cover: good packet A then bad packet B then good C -> reads return only A then C.
REQ-035 SHALL cover: rst_n low mid-packet after 2 beats -> empty_o=1, full_o=0, drop_o=0 next cycle.
REQ-036 SHALL cover: continuous pops during write of 2-beat packets across pointer wrap (40 packets) -> no loss, no duplication.
